// File: rtl/mdsa_result_streamer_if.sv
// Output stream bundle of the MDSA result streamer: one word per beat with
// valid/ready handshake, plus last-word flag and linear word position.
// master = the streamer driving words, slave = the downstream consumer.
interface mdsa_result_streamer_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [IW-1:0] m_index;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_index,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/mdsa_result_streamer.sv
// MDSA result streamer: snapshots a full sorted N x N matrix from the sorter's
// parallel bus in one cycle, then drains it one word per accepted beat.
// Build option: define MDSA_STREAM_SNAKE_EN to stream in boustrophedon order
// (odd rows reversed); otherwise words leave in plain row-major order.
module mdsa_result_streamer #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap_valid,
    input  logic [N*N*DW-1:0]   cap_data,
    output logic                cap_ready,
    output logic                done,
    output logic                ovf,
    input  logic                ovf_clr,
    mdsa_result_streamer_if.master m
);
    localparam int WORDS = N * N;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]    state_reg;
    logic [IW-1:0] index_reg;
    logic          done_reg;
    logic          ovf_reg;
    logic [IW-1:0] rd_addr;

    logic [DW-1:0] cap_words [WORDS];
    logic [DW-1:0] word_mem  [WORDS];

    logic capture;
    logic beat;
    logic last_beat;

    // A capture request is only honoured while idle; anything else is overflow.
    assign capture   = (state_reg == ST_IDLE) && cap_valid;
    assign beat      = (state_reg == ST_STREAM) && m.m_ready;
    assign last_beat = beat && (index_reg == LAST_IDX);

    // Slice the sorter bus into words, word i = cap_data[i*DW +: DW].
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slice
            assign cap_words[gi] = cap_data[gi*DW +: DW];
        end
    endgenerate

    // Snapshot the whole matrix in one cycle so the sorter is free immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) word_mem[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < WORDS; i++) word_mem[i] <= cap_words[i];
        end
    end

    // Frame sequencing: capture in IDLE, walk positions in STREAM, return after the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= last_beat;
            case (state_reg)
                ST_IDLE: begin
                    if (cap_valid) begin
                        state_reg <= ST_STREAM;
                        index_reg <= '0;
                    end
                end
                default: begin
                    if (beat) begin
                        if (index_reg == LAST_IDX) begin
                            state_reg <= ST_IDLE;
                            index_reg <= '0;
                        end else begin
                            index_reg <= index_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky overflow; a new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (cap_valid && (state_reg == ST_STREAM)) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

`ifdef MDSA_STREAM_SNAKE_EN
    localparam logic [31:0] NU = 32'(N);
    logic [31:0] pos;
    logic [31:0] row;
    logic [31:0] col;

    // Snake order: odd rows are read right to left.
    always_comb begin
        pos = 32'(index_reg);
        row = pos / NU;
        col = pos % NU;
        if (row[0]) col = NU - 32'd1 - col;
        rd_addr = IW'(row * NU + col);
    end
`else
    assign rd_addr = index_reg;
`endif

    // Output word is a pure function of state and position, so it holds during stalls.
    assign m.m_valid = (state_reg == ST_STREAM);
    assign m.m_data  = (state_reg == ST_STREAM) ? word_mem[rd_addr] : '0;
    assign m.m_last  = (state_reg == ST_STREAM) && (index_reg == LAST_IDX);
    assign m.m_index = index_reg;
    assign cap_ready = (state_reg == ST_IDLE);
    assign done      = done_reg;
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_mdsa_result_streamer.sv
// Bench for mdsa_result_streamer (N=8, DW=32): row-major or snake order
// (follows MDSA_STREAM_SNAKE_EN), backpressure, overflow and reset mid-stream.
module tb_mdsa_result_streamer;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int W  = N * N;

    logic            clk;
    logic            rst;
    logic            cap_valid;
    logic [W*DW-1:0] cap_data;
    logic            cap_ready;
    logic            done;
    logic            ovf;
    logic            ovf_clr;

    mdsa_result_streamer_if #(.N(N), .DW(DW)) sif ();

    mdsa_result_streamer #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .cap_ready (cap_ready),
        .done      (done),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .m         (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit ovf_exp = 1'b0;
    logic [DW-1:0] got [W];

    typedef struct {
        int            pos;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W*DW-1:0] make_mat(input int base);
        logic [W*DW-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int base, input int p);
`ifdef MDSA_STREAM_SNAKE_EN
        int r;
        int c;
        r = p / N;
        c = p % N;
        if (r % 2 == 1) c = N - 1 - c;
        return DW'(base + r * N + c);
`else
        return DW'(base + p);
`endif
    endfunction

    // Captures matrix 'base' and drains it. Optional: backpressure pattern
    // 1,0,0,1; overflow capture at beat ovf_at (with a simultaneous ovf_clr);
    // overflow on the last-beat edge; ovf_clr at clr_at; reset at beat rst_at.
    task automatic stream_frame(input int base, input bit bp, input int ovf_at,
                                input bit ovf_last, input int clr_at, input int rst_at,
                                output int cycles);
        int beats;
        bit inj_done;
        bit clr_done;
        bit aborted;
        beats = 0; inj_done = 0; clr_done = 0; aborted = 0; cycles = 0;
        cap_data  = make_mat(base);
        cap_valid = 1'b1;
        @(posedge clk);
        if (ovf_clr) ovf_exp = 1'b0;
        @(negedge clk);
        cap_valid = 1'b0;
        ovf_clr   = 1'b0;
        while (beats < W && cycles < 400) begin
            sif.m_ready = bp ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
            cap_valid = 1'b0;
            ovf_clr   = 1'b0;
            if (beats == ovf_at && !inj_done) begin
                cap_valid = 1'b1; ovf_clr = 1'b1; inj_done = 1;
            end
            if (ovf_last && beats == W - 1 && sif.m_ready) cap_valid = 1'b1;
            if (beats == clr_at && !clr_done) begin
                ovf_clr = 1'b1; clr_done = 1;
            end
            cap_data = cap_valid ? make_mat(base + 1000) : make_mat(base);
            if (beats == rst_at) begin
                cap_valid = 1'b0;
                ovf_clr   = 1'b0;
                rst = 1'b0;
                #1;
                check("rst_m_valid", 64'(sif.m_valid), 64'd0);
                check("rst_cap_ready", 64'(cap_ready), 64'd1);
                check("rst_m_index", 64'(sif.m_index), 64'd0);
                check("rst_m_data", 64'(sif.m_data), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                ovf_exp = 1'b0;
                $display("[TB] reset asserted at beat %0d", beats);
                aborted = 1;
                break;
            end
            check("m_valid", 64'(sif.m_valid), 64'd1);
            check("m_index", 64'(sif.m_index), 64'(beats));
            check("m_data", 64'(sif.m_data), 64'(exp_word(base, beats)));
            check("m_last", 64'(sif.m_last), 64'(beats == W - 1));
            check("cap_ready_busy", 64'(cap_ready), 64'd0);
            check("done_low", 64'(done), 64'd0);
            check("ovf", 64'(ovf), 64'(ovf_exp));
            if (sif.m_ready) begin
                got[beats] = sif.m_data;
                $display("[TB] base %0d beat %0d data %0h", base, beats, sif.m_data);
            end
            @(posedge clk);
            if (cap_valid) ovf_exp = 1'b1;
            else if (ovf_clr) ovf_exp = 1'b0;
            if (sif.m_ready) beats++;
            @(negedge clk);
            cycles++;
        end
        cap_valid = 1'b0;
        ovf_clr   = 1'b0;
        if (!aborted) begin
            check("beats_accepted", 64'(beats), 64'(W));
            check("end_m_valid", 64'(sif.m_valid), 64'd0);
            check("end_m_last", 64'(sif.m_last), 64'd0);
            check("end_cap_ready", 64'(cap_ready), 64'd1);
            check("end_done", 64'(done), 64'd1);
            check("end_ovf", 64'(ovf), 64'(ovf_exp));
        end
    endtask

    initial begin
        int cyc;
`ifdef MDSA_STREAM_SNAKE_EN
        vecs[0]  = '{0, 0};   vecs[1]  = '{7, 7};   vecs[2]  = '{8, 15};
        vecs[3]  = '{9, 14};  vecs[4]  = '{15, 8};  vecs[5]  = '{16, 16};
        vecs[6]  = '{23, 23}; vecs[7]  = '{24, 31}; vecs[8]  = '{31, 24};
        vecs[9]  = '{56, 63}; vecs[10] = '{62, 57}; vecs[11] = '{63, 56};
`else
        vecs[0]  = '{0, 0};   vecs[1]  = '{7, 7};   vecs[2]  = '{8, 8};
        vecs[3]  = '{9, 9};   vecs[4]  = '{15, 15}; vecs[5]  = '{16, 16};
        vecs[6]  = '{23, 23}; vecs[7]  = '{24, 24}; vecs[8]  = '{31, 31};
        vecs[9]  = '{56, 56}; vecs[10] = '{62, 62}; vecs[11] = '{63, 63};
`endif
        rst = 1'b0;
        cap_valid = 1'b0;
        cap_data = '0;
        ovf_clr = 1'b0;
        sif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_m_valid", 64'(sif.m_valid), 64'd0);
        check("reset_m_last", 64'(sif.m_last), 64'd0);
        check("reset_m_index", 64'(sif.m_index), 64'd0);
        check("reset_m_data", 64'(sif.m_data), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        rst = 1'b1;
        #1;
        check("reset_cap_ready", 64'(cap_ready), 64'd1);
        @(negedge clk);

        // Full-rate frame: one word per cycle, then spot checks from the table.
        stream_frame(0, 1'b0, -1, 1'b0, -1, -1, cyc);
        check("throughput_cycles", 64'(cyc), 64'(W));
        for (int i = 0; i < 12; i++)
            check($sformatf("order_pos%0d", vecs[i].pos), 64'(got[vecs[i].pos]), 64'(vecs[i].exp));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        // Backpressure frame.
        stream_frame(100, 1'b1, -1, 1'b0, -1, -1, cyc);
        @(negedge clk);

        // Overflow at beat 10 (with a same-cycle clear), clear at 20, overflow on last beat.
        stream_frame(300, 1'b0, 10, 1'b1, 20, -1, cyc);
        check("ovf_after_last", 64'(ovf), 64'd1);
        // Fastest next capture, one cycle after the last beat, while clearing ovf.
        ovf_clr = 1'b1;
        stream_frame(400, 1'b0, -1, 1'b0, -1, -1, cyc);
        check("ovf_cleared", 64'(ovf), 64'd0);
        @(negedge clk);

        // Reset mid-stream at beat 20, then a clean frame.
        stream_frame(500, 1'b0, -1, 1'b0, -1, 20, cyc);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 64'(done), 64'd0);
            check("idle_after_rst", 64'(sif.m_valid), 64'd0);
        end
        stream_frame(600, 1'b0, -1, 1'b0, -1, -1, cyc);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mdsa_result_streamer.md
# mdsa_result_streamer

Drain stage for the MDSA sorter. Captures one complete sorted N×N matrix from the sorter's parallel `data_out_final` bus in a single cycle, then streams it word by word to downstream logic over a valid/ready interface. This frees the sorter to accept the next matrix while the previous result is still draining.

## Interface

**Parameters**
- `N`, 8: matrix dimension; rows = columns = N.
- `DW`, 32: word width in bits.

**Ports**
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `cap_valid`, in, 1: `cap_data` holds a complete sorted matrix.
- `cap_data`, in, N·N·DW: matrix in sorter bus layout; word (r,c) = `cap_data[(r·N+c)·DW +: DW]`, row r 0-based.
- `cap_ready`, out, 1: block is idle and can capture.
- `m_data`, out, DW: current output word.
- `m_valid`, out, 1: `m_data` is valid.
- `m_ready`, in, 1: downstream accepts the word.
- `m_last`, out, 1: current word is the final (N·N-th) word.
- `m_index`, out, clog2(N·N): linear position of the current word in the output sequence, 0..N·N-1.
- `done`, out, 1: one-cycle pulse after the last word is accepted.
- `ovf`, out, 1: sticky flag; a capture was attempted while busy.
- `ovf_clr`, in, 1: synchronous clear of `ovf`.

## Operation

- **State machine:** IDLE, STREAM.
- **IDLE**
  - `cap_ready`=1 (decoded combinationally from state only).
  - On `cap_valid`=1: latch all of `cap_data` into an internal N·N·DW buffer, set `m_index`=0, go to STREAM.
- **STREAM**
  - `cap_ready`=0, `m_valid`=1. `m_data` = buffer word at the position given by `m_index` (see Configuration).
  - Beat accepted when `m_valid && m_ready`; `m_index` then increments by 1.
  - When a beat is accepted with `m_index`=N·N-1: go to IDLE, pulse `done` on the following cycle, reset `m_index` to 0.
- **Ordering rule:** `m_data`, `m_last` and `m_index` hold stable while `m_valid && !m_ready`.
- **Overflow:** `cap_valid`=1 while in STREAM sets `ovf`. The request is ignored and the buffer is not modified.
  - `ovf_clr` clears `ovf`.
  - If a set and a clear occur in the same cycle, the set wins.
- **Reset values:** state=IDLE, `m_valid`=0, `m_last`=0, `m_index`=0, `m_data`=0, `done`=0, `ovf`=0, buffer=0. `cap_ready`=1 as soon as reset is deasserted.
- **Reset mid-stream:** reset takes effect immediately (asynchronous). `m_valid` drops without completing the frame, and `done` is not pulsed.

## Timing

- **Capture to first word:** capture on edge k; `m_valid`=1 with word 0 visible after edge k.
- **Throughput:** with `m_ready` held at 1, one word per cycle; a frame takes N·N cycles of `m_valid`.
- **End of frame:** last beat accepted on edge t; after t, `m_valid`=0, `cap_ready`=1 and `done`=1 (for one cycle).
- **Fastest next capture:** edge t+1. Minimum frame-to-frame spacing is N·N+1 cycles.
- **Capture coinciding with the last beat:** a `cap_valid` on the same edge as the last accepted beat is not captured, because `cap_ready` was 0. It sets `ovf`.
- **`m_last`:** equals (`m_index`==N·N-1) && `m_valid`.

## Configuration

- **`MDSA_STREAM_SNAKE_EN` defined:** words stream in snake (boustrophedon) order, the final order of the shear sort.
  - Even rows are read c=0..N-1.
  - Odd rows are read c=N-1..0.
  - Position p maps to row r=p/N; column c=p%N for even r, N-1-p%N for odd r.
- **`MDSA_STREAM_SNAKE_EN` not defined:** plain row-major order; position p maps to word p of the buffer.
- Handshake, timing and all other behaviour are identical in both builds.

## Test plan

- **Row-major order** (macro off): word(r,c)=r·8+c, `cap_valid` pulsed, `m_ready`=1. Expect 64 beats, values 0..63 on consecutive cycles, `m_last` only on 63, `done` one cycle later.
- **Snake order** (macro on): same stimulus. Expect the sequence 0..7, 15..8, 16..23, 31..24, …, 63..56.
- **Backpressure:** toggle `m_ready` 1,0,0,1,… Expect `m_data` and `m_index` stable while stalled, no word dropped or repeated, 64 accepted beats total.
- **Overflow:** assert `cap_valid` with a different matrix at beat 10, and again on the last-beat edge. Expect `ovf`=1, output stream unchanged, `ovf_clr` returns `ovf` to 0. A capture one cycle after `done` succeeds.
- **Reset mid-stream:** assert `rst`=0 at beat 20. Expect `m_valid`=0, `cap_ready`=1, `m_index`=0 and `done` not pulsed. A new capture then streams from word 0.
